// File: rtl/psram_qspi_slave.sv
// psram_qspi_slave: clock-oversampled QSPI PSRAM slave serving reads/writes from an internal byte array.
// Optional QPI-mode command handling (0x35 enter / 0xF5 exit) is compiled in with PSRAM_QPI_EN.
module psram_qspi_slave #(
  parameter int ADDR_W      = 24,
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_CYCLES = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] dio_i,
  output logic [3:0] dio_o,
  output logic       dio_oe,
  output logic       busy,
  output logic       err,
  output logic       qpi
);
  localparam int ANIB  = (ADDR_W + 3) / 4;
  localparam int AW    = ANIB * 4;
  localparam int IW    = $clog2(MEM_BYTES);
  localparam int CMX0  = ANIB > 8 ? ANIB : 8;
  localparam int CMAX  = WAIT_CYCLES > CMX0 ? WAIT_CYCLES : CMX0;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int WLAST = WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0;

  typedef enum logic [2:0] {CMD, ADDR, WAIT, RDATA, WDATA, DONE, ERR} state_t;

  logic [SYNC_STAGES-1:0] sck_q, ce_q;
  logic                   sck_prev_q, sck_s, ce_s, sck_rise, sck_fall;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [6:0]             sh_q, sh_d;
  logic [AW-1:0]          addr_q, addr_d, addr_inc;
  logic                   rd_q, rd_d, nib_q, nib_d, err_q, err_d, qpi_q, qpi_d, we, qpi_en;
  logic [3:0]             wbuf_q, wbuf_d, dout_q, dout_d;
  logic [7:0]             cmd_nx, mem_rd;
  logic [7:0]             mem [MEM_BYTES];

`ifdef PSRAM_QPI_EN
  assign qpi_en = 1'b1;
`else
  assign qpi_en = 1'b0;
`endif

  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign ce_s     = ce_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cmd_nx   = qpi_q ? {sh_q[3:0], dio_i} : {sh_q, dio_i[0]};
  assign mem_rd   = mem[addr_q[IW-1:0]];

  always_comb begin
    addr_inc          = addr_q;
    addr_inc[IW-1:0]  = addr_q[IW-1:0] + IW'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    nib_d   = nib_q;
    wbuf_d  = wbuf_q;
    dout_d  = dout_q;
    qpi_d   = qpi_q;
    err_d   = 1'b0;
    we      = 1'b0;
    if (ce_s) begin
      state_d = CMD;
      cnt_d   = '0;
      nib_d   = 1'b0;
    end else begin
      case (state_q)
        CMD: if (sck_rise) begin
          sh_d  = cmd_nx[6:0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == (qpi_q ? CW'(1) : CW'(7))) begin
            cnt_d = '0;
            if (cmd_nx == 8'hEB || cmd_nx == 8'h38) begin
              state_d = ADDR;
              rd_d    = cmd_nx == 8'hEB;
            end else if (qpi_en && cmd_nx == (qpi_q ? 8'hF5 : 8'h35)) begin
              state_d = DONE;
              qpi_d   = ~qpi_q;
            end else begin
              state_d = ERR;
              err_d   = 1'b1;
            end
          end
        end
        ADDR: if (sck_rise) begin
          addr_d = {addr_q[AW-5:0], dio_i};
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(ANIB - 1)) begin
            cnt_d   = '0;
            nib_d   = 1'b0;
            state_d = !rd_q ? WDATA : (WAIT_CYCLES == 0 ? RDATA : WAIT);
          end
        end
        WAIT: if (sck_rise) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WLAST)) begin
            cnt_d   = '0;
            state_d = RDATA;
          end
        end
        RDATA: if (sck_fall) begin
          dout_d = nib_q ? mem_rd[3:0] : mem_rd[7:4];
          nib_d  = ~nib_q;
          addr_d = nib_q ? addr_inc : addr_q;
        end
        WDATA: if (sck_rise) begin
          we     = nib_q;
          wbuf_d = nib_q ? wbuf_q : dio_i;
          addr_d = nib_q ? addr_inc : addr_q;
          nib_d  = ~nib_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_q      <= '0;
      ce_q       <= '1;
      sck_prev_q <= 1'b0;
      state_q    <= CMD;
      cnt_q      <= '0;
      sh_q       <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      nib_q      <= 1'b0;
      wbuf_q     <= '0;
      dout_q     <= '0;
      err_q      <= 1'b0;
      qpi_q      <= 1'b0;
    end else begin
      sck_q      <= SYNC_STAGES'({sck_q, sck});
      ce_q       <= SYNC_STAGES'({ce_q, ce_n});
      sck_prev_q <= sck_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      nib_q      <= nib_d;
      wbuf_q     <= wbuf_d;
      dout_q     <= dout_d;
      err_q      <= err_d;
      qpi_q      <= qpi_d;
    end
  end

  // Array has no reset so contents survive reset_n pulses.
  always_ff @(posedge clock) begin
    if (we) mem[addr_q[IW-1:0]] <= {wbuf_q, dio_i};
  end

  assign dio_o  = dout_q;
  assign dio_oe = (state_q == RDATA) && !ce_s;
  assign busy   = !ce_s;
  assign err    = err_q;
  assign qpi    = qpi_q;
endmodule

// File: doc/psram_qspi_slave.md
Name: psram_qspi_slave

Overview:
- Synthesizable, single-clock successor to the sck-clocked PSRAM device model.
- Oversamples the QSPI bus (sck, ce_n, dio) with the system clock.
- Decodes quad read/write and QPI-mode commands, and serves data from an internal byte array.
- Sits on the SoC's PSRAM pins in simulation and FPGA builds, and replaces the DPI-backed model.

Parameters:
- ADDR_W, 24: address bits received in the ADDR phase.
- MEM_BYTES, 4096: internal array size in bytes, power of two; the byte index is addr mod MEM_BYTES.
- WAIT_CYCLES, 6: dummy sck rises between address and read data for 0xEB.
- SYNC_STAGES, 2: synchroniser depth on sck and ce_n.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sck  in  1  QSPI serial clock (asynchronous to clock).
- ce_n  in  1  chip enable, active-low.
- dio_i  in  4  data pins sampled from the bus.
- dio_o  out  4  data pins driven to the bus.
- dio_oe  out  1  output enable for dio_o; the top-level tristates on it.
- busy  out  1  high while ce_n (synchronised) is low.
- err  out  1  one-clock pulse on an unsupported command.
- qpi  out  1  current QPI-mode flag.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - dio_o=0, dio_oe=0, busy=0, err=0, qpi=0, state=CMD, counters=0, addr=0.
  - Array contents are not reset.
- Synchronisation and edge detection:
  - sck and ce_n each pass through SYNC_STAGES flops.
  - sck_rise/sck_fall are single-clock pulses from the synchronised value.
  - Required bus timing: sck high and low phases each ≥ SYNC_STAGES+1 clock periods.
- ce_n synchronised high:
  - state=CMD, counters=0, dio_oe=0 in the same clock. This aborts any transaction.
  - If ce_n rises in the same clock as an sck edge, ce_n wins and the edge is ignored.
- CMD state:
  - SPI mode: 8 sck_rise, sampling dio_i[0] MSB-first.
  - QPI mode: 2 sck_rise, sampling dio_i[3:0], high nibble first.
  - Decode on the last rise:
    - 0xEB → ADDR (read).
    - 0x38 → ADDR (write).
    - 0x35 (SPI mode) / 0xF5 (QPI mode) → toggle qpi, go to DONE.
    - Anything else → ERR, with err=1 for exactly that clock.
- ADDR state:
  - ceil(ADDR_W/4) rises; each samples a nibble MSB-first into addr.
  - Then go to WAIT (read) or WDATA (write).
- WAIT state:
  - Count WAIT_CYCLES rises, then go to RDATA.
  - If WAIT_CYCLES=0, go straight to RDATA.
- RDATA state:
  - dio_oe=1.
  - On each sck_fall, drive the next nibble: high nibble of mem[addr], then low nibble.
  - After the low nibble is driven, addr increments and wraps modulo MEM_BYTES.
  - The first nibble is driven on the sck_fall that follows the last WAIT/ADDR rise.
  - dio_o changes SYNC_STAGES+1 clocks after the physical sck fall.
- WDATA state:
  - On each sck_rise, sample a nibble, high first.
  - On the second nibble, write the byte to mem[addr mod MEM_BYTES] and increment addr (wrap).
  - A partial byte at ce_n deassertion is discarded.
- DONE / ERR states: ignore all sck edges until ce_n goes high. dio_oe stays 0.
- qpi flag: changed only by the 0x35/0xF5 commands or by reset; it persists across ce_n cycles.
- busy: equals the inverse of synchronised ce_n.
- Reset mid-operation: all outputs return to their reset values immediately; the next transaction starts in CMD with SPI mode.

Optional Feature:
- Macro: PSRAM_QPI_EN.
- Defined: the 0x35/0xF5 QPI handling described above is compiled in.
- Undefined:
  - qpi is tied to 0 and the command phase is always SPI 8-bit.
  - 0x35 and 0xF5 are treated as unsupported: they go to ERR and pulse err.

Test Plan:
- Write 0x38, addr 0x000010, data A5 3C; then read 0xEB at addr 0x10 → after 6 dummy rises, dio_o shows nibbles A,5,3,C with dio_oe=1.
- Write 0x38 at addr 0xFFF (MEM_BYTES=4096), data 11 22 → read at 0xFFF returns 11; read at 0x000 returns 22.
- Command 0x9F → err high for exactly one clock, dio_oe stays 0, later sck edges ignored, busy drops on ce_n high.
- With PSRAM_QPI_EN: 0x35 → qpi=1; the next transaction issues 0xEB in 2 rises and reads correct data; 0xF5 → qpi=0. Without the macro: 0x35 → err pulse, qpi stays 0.
- Abort: write 0x38, addr 0x20, one data nibble 0xF, then ce_n high → mem[0x20] keeps its prior value (written 0x00 earlier); the next command decodes normally.
- Assert reset_n low mid-RDATA → dio_oe=0 and dio_o=0 asynchronously; after release, qpi=0 and the previously written array data still reads back unchanged.
